// File: rtl/mem_pkg.sv
// mem_pkg
// Shared types and constants for the RV32I memory access controller.
//   state_e : controller FSM states (encoding is visible on the debug port)
//   chan_e  : which requester currently owns the bus
//   SZ_*    : data_size encodings for byte / half / word accesses
//   isMisaligned : alignment rule for a data access of a given size
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_e;

  typedef enum logic {
    CH_INSTR = 1'b0,
    CH_DATA  = 1'b1
  } chan_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // A data access is misaligned when its offset is not a multiple of its
  // size. Size code 3 has no meaning and is rejected the same way.
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [1:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Purely combinational byte-lane steering for the shared 32-bit bus.
//   i_size, i_offset : access size and byte offset within the word
//   i_unsigned       : zero-extend loads when 1, sign-extend when 0
//   i_wdata          : store data, least significant bytes meaningful
//   i_rdata          : raw word returned by the bus
//   o_sel            : byte-lane enables for the access
//   o_wdata          : store data replicated onto every lane it may land on
//   o_load           : selected byte/half/word, extended to 32 bits
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [31:0] w_shifted;

  // Bring the addressed byte down to bit 0 so byte and half extraction
  // share one shifter; legal words always have offset 0.
  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Store side: replicate the data so whichever lanes are enabled carry
  // the right bytes, and enable exactly the lanes the access covers.
  always_comb begin
    o_sel   = 4'b0000;
    o_wdata = '0;
    case (i_size)
      SZ_B: begin
        o_sel   = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_sel   = 4'b0011 << i_offset;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SZ_W: begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_sel   = 4'b0000;
        o_wdata = '0;
      end
    endcase
  end

  // Load side: pick the byte or half and extend it to a full register.
  always_comb begin
    o_load = '0;
    case (i_size)
      SZ_B:    o_load = i_unsigned ? {24'd0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_load = i_unsigned ? {16'd0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    o_load = w_shifted;
      default: o_load = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Arbitrates the fetch unit and the MEM stage onto one shared memory bus.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_instr_* / o_instr_*   : fetch request (word), returned word, done pulse
//   i_data_*  / o_data_*    : load/store request, extended load data,
//                             done pulse, error pulse (misaligned/timeout)
//   o_bus_*                 : word address, lane data, lane enables, strobes
//   i_bus_rdata, i_bus_busy : bus read data and wait indication
//   o_state                 : current FSM state for debug
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_instr_req,
  input  logic [ADDR_W-1:0] i_instr_addr,
  output logic [31:0]       o_instr_rdata,
  output logic              o_instr_valid,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [1:0]        i_data_size,
  input  logic              i_data_unsigned,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [31:0]       i_data_wdata,
  output logic [31:0]       o_data_rdata,
  output logic              o_data_valid,
  output logic              o_data_err,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_sel,
  output logic              o_bus_read,
  output logic              o_bus_write,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_busy,
  output logic [2:0]        o_state
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  state_e            r_state, w_next;
  chan_e             r_ch, w_grant_ch;
  logic              w_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_we, r_unsigned;
  logic [31:0]       r_wdata;
  logic [15:0]       r_cnt;
  logic              r_data_last;
  logic [31:0]       r_instr_rdata, r_data_rdata;
  logic              w_strobe, w_capture, w_expired;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdata_rep, w_load_ext;

  mem_lane_align u_lane (
    .i_size     (r_size),
    .i_offset   (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (i_bus_rdata),
    .o_sel      (w_sel),
    .o_wdata    (w_wdata_rep),
    .o_load     (w_load_ext)
  );

  // Round-robin between the two requesters: on contention the channel that
  // did not complete last wins, so neither can starve the other.
  always_comb begin
    w_grant    = i_instr_req | i_data_req;
    w_grant_ch = CH_INSTR;
    if (i_instr_req && i_data_req)
      w_grant_ch = r_data_last ? CH_INSTR : CH_DATA;
    else if (i_data_req)
      w_grant_ch = CH_DATA;
  end

  assign w_strobe  = (r_state == ISSUE) || (r_state == WAIT);
  assign w_capture = w_strobe && !i_bus_busy;
  assign w_expired = (r_state == WAIT) && i_bus_busy && (r_cnt == LP_TIMEOUT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic. Misaligned data accesses skip the bus entirely; a
  // stalled fetch still completes (with zero data) because fetch errors
  // have no reporting path.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:
        if (w_grant)
          w_next = (w_grant_ch == CH_DATA &&
                    isMisaligned(i_data_size, i_data_addr[1:0])) ? ERR : ISSUE;
      ISSUE:
        w_next = i_bus_busy ? WAIT : RESP;
      WAIT:
        if (!i_bus_busy)    w_next = RESP;
        else if (w_expired) w_next = (r_ch == CH_DATA) ? ERR : RESP;
      RESP:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Transaction datapath: latch the winning request, count busy cycles,
  // and capture read data into the owning channel's holding register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ch          <= CH_INSTR;
      r_addr        <= '0;
      r_size        <= SZ_B;
      r_we          <= 1'b0;
      r_unsigned    <= 1'b0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_data_last   <= 1'b0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      if (r_state == IDLE && w_grant) begin
        r_ch <= w_grant_ch;
        if (w_grant_ch == CH_DATA) begin
          r_addr     <= i_data_addr;
          r_size     <= i_data_size;
          r_we       <= i_data_we;
          r_unsigned <= i_data_unsigned;
          r_wdata    <= i_data_wdata;
        end else begin
          r_addr     <= i_instr_addr;
          r_size     <= SZ_W;
          r_we       <= 1'b0;
          r_unsigned <= 1'b0;
          r_wdata    <= '0;
        end
      end

      if (r_state == ISSUE)
        r_cnt <= 16'd1;
      else if (r_state == WAIT && i_bus_busy && !w_expired)
        r_cnt <= r_cnt + 16'd1;

      if (w_capture) begin
        if (r_ch == CH_INSTR)
          r_instr_rdata <= i_bus_rdata;
        else if (!r_we)
          r_data_rdata <= w_load_ext;
      end else if (w_expired && r_ch == CH_INSTR) begin
        r_instr_rdata <= '0;
      end

      if (r_state == RESP)
        r_data_last <= (r_ch == CH_DATA);
    end
  end

  // Outputs. Bus fields are only driven while a strobe is active so the
  // bus sees a clean zero between transactions.
  always_comb begin
    o_bus_read  = 1'b0;
    o_bus_write = 1'b0;
    o_bus_addr  = '0;
    o_bus_sel   = 4'b0000;
    o_bus_wdata = '0;
    if (w_strobe) begin
      o_bus_read  = !r_we;
      o_bus_write = r_we;
      o_bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
      o_bus_sel   = w_sel;
      o_bus_wdata = w_wdata_rep;
    end
    o_instr_valid = (r_state == RESP) && (r_ch == CH_INSTR);
    o_data_valid  = (r_state == RESP) && (r_ch == CH_DATA);
    o_data_err    = (r_state == ERR);
    o_state       = r_state;
  end

  assign o_instr_rdata = r_instr_rdata;
  assign o_data_rdata  = r_data_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed and randomized checks of mem_access_ctrl against a behavioural
// model built from byte arithmetic. TIMEOUT is reduced to 4 so stall limits
// are reachable in a few cycles.
module tb_mem_access_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic        clk, rst;
  logic        instrReq;
  logic [31:0] instrAddr, instrRdata;
  logic        instrValid;
  logic        dataReq, dataWe, dataUnsigned;
  logic [1:0]  dataSize;
  logic [31:0] dataAddr, dataWdata, dataRdata;
  logic        dataValid, dataErr;
  logic [31:0] busAddr, busWdata, busRdata;
  logic [3:0]  busSel;
  logic        busRead, busWrite, busBusy;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastLoad, lastInstr;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_instr_req     (instrReq),
    .i_instr_addr    (instrAddr),
    .o_instr_rdata   (instrRdata),
    .o_instr_valid   (instrValid),
    .i_data_req      (dataReq),
    .i_data_we       (dataWe),
    .i_data_size     (dataSize),
    .i_data_unsigned (dataUnsigned),
    .i_data_addr     (dataAddr),
    .i_data_wdata    (dataWdata),
    .o_data_rdata    (dataRdata),
    .o_data_valid    (dataValid),
    .o_data_err      (dataErr),
    .o_bus_addr      (busAddr),
    .o_bus_wdata     (busWdata),
    .o_bus_sel       (busSel),
    .o_bus_read      (busRead),
    .o_bus_write     (busWrite),
    .i_bus_rdata     (busRdata),
    .i_bus_busy      (busBusy),
    .o_state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something below never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) stepCycle();
    rst = 1'b0;
    lastLoad  = '0;
    lastInstr = '0;
  endtask

  // One complete transaction on a single channel. Expected behaviour comes
  // from the access width in bytes: alignment by modulo, lanes and
  // replication by multiplication, extension by subtracting 2^bits.
  task automatic applyStimulus(input string tag, input bit isInstr,
                               input bit we, input logic [1:0] sz,
                               input logic [31:0] addr, input bit uns,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input int busyN);
    int nBytes, off, cyc, firstStrobe, expDone;
    bit done, sawErr, sawValid, sawRead, sawWrite, misal, timedOut, expErr;
    logic [31:0] selSeen, addrSeen, wdSeen, mask, raw, expLoad, expSel, expWd;

    if (isInstr)         nBytes = 4;
    else if (sz == 2'd0) nBytes = 1;
    else if (sz == 2'd1) nBytes = 2;
    else if (sz == 2'd2) nBytes = 4;
    else                 nBytes = 0;
    off      = int'(addr % 32'd4);
    misal    = (nBytes == 0) ? 1'b1 : ((addr % nBytes) != 0);
    timedOut = !misal && (busyN >= TB_TIMEOUT + 1);
    expDone  = misal ? 1 : (timedOut ? TB_TIMEOUT + 2 : 2 + busyN);
    expErr   = misal || (timedOut && !isInstr);
    expSel   = (((32'd1 << nBytes) - 32'd1) << off) & 32'hF;
    if (nBytes == 1)      expWd = (wd & 32'hFF) * 32'h0101_0101;
    else if (nBytes == 2) expWd = (wd & 32'hFFFF) * 32'h0001_0001;
    else                  expWd = wd;
    mask    = (nBytes >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nBytes)) - 32'd1;
    raw     = (rd >> (8 * off)) & mask;
    expLoad = raw;
    if (!uns && nBytes > 0 && nBytes < 4 && raw >= (32'd1 << (8 * nBytes - 1)))
      expLoad = raw - (32'd1 << (8 * nBytes));

    if (isInstr) begin
      instrReq  = 1'b1;
      instrAddr = addr;
    end else begin
      dataReq      = 1'b1;
      dataWe       = we;
      dataSize     = sz;
      dataAddr     = addr;
      dataUnsigned = uns;
      dataWdata    = wd;
    end
    busRdata = rd;
    busBusy  = 1'b0;
    cyc = 0; done = 0; sawErr = 0; sawValid = 0; sawRead = 0; sawWrite = 0;
    firstStrobe = -1; selSeen = '0; addrSeen = '0; wdSeen = '0;

    while (!done && cyc < 40) begin
      stepCycle();
      cyc++;
      busBusy = (cyc <= busyN);
      if (busRead || busWrite) begin
        if (firstStrobe < 0) firstStrobe = cyc;
        sawRead  = sawRead | busRead;
        sawWrite = sawWrite | busWrite;
        selSeen  = {28'd0, busSel};
        addrSeen = busAddr;
        wdSeen   = busWdata;
      end
      if (instrValid || dataValid || dataErr) begin
        done     = 1'b1;
        sawValid = isInstr ? instrValid : dataValid;
        sawErr   = dataErr;
        instrReq = 1'b0;
        dataReq  = 1'b0;
        busBusy  = 1'b0;
      end
    end

    checkOutput({tag, ".done"},   32'(done), 32'd1);
    checkOutput({tag, ".cycle"},  32'(cyc), 32'(expDone));
    checkOutput({tag, ".valid"},  32'(sawValid), 32'(!expErr));
    checkOutput({tag, ".err"},    32'(sawErr), 32'(expErr));
    checkOutput({tag, ".strobe"}, 32'(firstStrobe), misal ? 32'hFFFF_FFFF : 32'd1);
    if (!misal) begin
      checkOutput({tag, ".rd"},   32'(sawRead), 32'(isInstr || !we));
      checkOutput({tag, ".wr"},   32'(sawWrite), 32'(!isInstr && we));
      checkOutput({tag, ".sel"},  selSeen, expSel);
      checkOutput({tag, ".addr"}, addrSeen, addr & ~32'd3);
      if (!isInstr && we) checkOutput({tag, ".wdata"}, wdSeen, expWd);
    end
    if (isInstr) begin
      lastInstr = timedOut ? 32'd0 : rd;
      checkOutput({tag, ".irdata"}, instrRdata, lastInstr);
    end else begin
      if (!misal && !timedOut && !we) lastLoad = expLoad;
      checkOutput({tag, ".drdata"}, dataRdata, lastLoad);
    end

    stepCycle();
    checkOutput({tag, ".after"},
                {24'd0, state, busRead, busWrite, instrValid, dataValid, dataErr},
                32'd0);
  endtask

  initial begin
    int cyc, nPulse, seq, extra;
    bit rIsInstr, rWe, rUns;
    logic [1:0]  rSz;
    logic [31:0] rAddr, rWd, rRd;
    int rBusy;

    rst = 1'b1;
    instrReq = 0; instrAddr = '0; dataReq = 0; dataWe = 0; dataSize = '0;
    dataUnsigned = 0; dataAddr = '0; dataWdata = '0; busRdata = '0; busBusy = 0;
    lastLoad = '0; lastInstr = '0;

    // Reset state.
    repeat (3) stepCycle();
    checkOutput("rst.state",  {29'd0, state}, 32'd0);
    checkOutput("rst.strobe", {30'd0, busRead, busWrite}, 32'd0);
    checkOutput("rst.bus",    busAddr | busWdata | {28'd0, busSel}, 32'd0);
    checkOutput("rst.pulses", {29'd0, instrValid, dataValid, dataErr}, 32'd0);
    checkOutput("rst.rdata",  instrRdata | dataRdata, 32'd0);
    rst = 1'b0;
    stepCycle();

    // Loads with lane extraction and extension.
    applyStimulus("lw100", 0, 0, 2'd2, 32'h100, 0, 32'h0, 32'hDEAD_BEEF, 0);
    checkOutput("lw100.lit", dataRdata, 32'hDEAD_BEEF);
    applyStimulus("lb103", 0, 0, 2'd0, 32'h103, 0, 32'h0, 32'h8000_0000, 0);
    checkOutput("lb103.lit", dataRdata, 32'hFFFF_FF80);
    applyStimulus("lbu103", 0, 0, 2'd0, 32'h103, 1, 32'h0, 32'h8000_0000, 0);
    checkOutput("lbu103.lit", dataRdata, 32'h0000_0080);
    applyStimulus("lh102", 0, 0, 2'd1, 32'h102, 0, 32'h0, 32'h8000_0000, 0);
    checkOutput("lh102.lit", dataRdata, 32'hFFFF_8000);

    // Stores, misalignment and stalls.
    applyStimulus("sh102", 0, 1, 2'd1, 32'h102, 0, 32'h0000_ABCD, 32'h0, 0);
    applyStimulus("lw101", 0, 0, 2'd2, 32'h101, 0, 32'h0, 32'h1111_1111, 0);
    applyStimulus("sz3",   0, 0, 2'd3, 32'h100, 0, 32'h0, 32'h1111_1111, 0);
    applyStimulus("swto",  0, 1, 2'd2, 32'h104, 0, 32'hCAFE_F00D, 32'h0, 20);
    applyStimulus("lwb3",  0, 0, 2'd2, 32'h108, 0, 32'h0, 32'h0BAD_CAFE, 3);
    applyStimulus("lwb4",  0, 0, 2'd2, 32'h10C, 0, 32'h0, 32'h5555_AAAA, 4);
    applyStimulus("if1",   1, 0, 2'd2, 32'h400, 0, 32'h0, 32'h0000_0013, 1);
    applyStimulus("ifto",  1, 0, 2'd2, 32'h404, 0, 32'h0, 32'hFFFF_FFFF, 5);

    // Contention: starting with data_last clear, grants must alternate.
    doReset();
    instrReq = 1; instrAddr = 32'h300;
    dataReq = 1; dataWe = 0; dataSize = 2'd2; dataAddr = 32'h200; dataUnsigned = 0;
    busBusy = 0; busRdata = 32'h1234_5678;
    cyc = 0; nPulse = 0; seq = 0;
    while (nPulse < 4 && cyc < 40) begin
      stepCycle();
      cyc++;
      if (instrValid || dataValid) begin
        seq = seq * 10 + (dataValid ? 1 : 0) + (instrValid ? 2 : 0);
        nPulse++;
        if (nPulse == 4) begin
          instrReq = 0;
          dataReq  = 0;
        end
      end
    end
    extra = 0;
    repeat (5) begin
      stepCycle();
      if (instrValid || dataValid || dataErr) extra++;
    end
    checkOutput("arb.order", 32'(seq), 32'd1212);
    checkOutput("arb.cycle", 32'(cyc), 32'd11);
    checkOutput("arb.extra", 32'(extra), 32'd0);
    checkOutput("arb.drdata", dataRdata, 32'h1234_5678);
    checkOutput("arb.irdata", instrRdata, 32'h1234_5678);

    // Reset while stalled in WAIT: abort silently.
    dataReq = 1; dataWe = 1; dataSize = 2'd2; dataAddr = 32'h104;
    dataWdata = 32'hA5A5_5A5A; busBusy = 1;
    stepCycle();
    stepCycle();
    checkOutput("rstw.pre", {28'd0, state, busWrite}, {28'd0, 3'd2, 1'b1});
    rst = 1; dataReq = 0;
    stepCycle();
    checkOutput("rstw.state", {29'd0, state}, 32'd0);
    checkOutput("rstw.out", {28'd0, busRead, busWrite, dataValid, dataErr}, 32'd0);
    rst = 0; busBusy = 0;
    lastLoad = '0; lastInstr = '0;
    extra = 0;
    repeat (5) begin
      stepCycle();
      if (instrValid || dataValid || dataErr || busRead || busWrite) extra++;
    end
    checkOutput("rstw.quiet", 32'(extra), 32'd0);

    // Randomized single-channel transactions.
    for (int i = 0; i < 40; i++) begin
      rIsInstr = ($urandom_range(0, 3) == 0);
      rWe      = $urandom_range(0, 1) == 1;
      rSz      = 2'($urandom_range(0, 3));
      rAddr    = $urandom;
      if (rIsInstr) rAddr = rAddr & ~32'd3;
      rUns     = $urandom_range(0, 1) == 1;
      rWd      = $urandom;
      rRd      = $urandom;
      rBusy    = $urandom_range(0, 6);
      applyStimulus($sformatf("rnd%0d", i), rIsInstr, rWe, rSz, rAddr, rUns,
                    rWd, rRd, rBusy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
